// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types, constants and byte-swap helper for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  localparam int MAX_PORTS  = 8;
  localparam int PORT_ID_W  = $clog2(MAX_PORTS);
  localparam int MAX_DATA_W = 128;

  // One entry of the read-response pipeline
  typedef struct packed {
    logic                 valid;
    logic [PORT_ID_W-1:0] port_id;
  } resp_tag_t;

  // Reverse the lowest nbytes bytes of d; bytes above nbytes come back as zero
  function automatic logic [MAX_DATA_W-1:0] byte_swap(input logic [MAX_DATA_W-1:0] d,
                                                      input int                    nbytes);
    logic [MAX_DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_DATA_W / 8; i++) begin
      if (i < nbytes) begin
        r = r | (((d >> ((nbytes - 1 - i) * 8)) & MAX_DATA_W'(8'hFF)) << (i * 8));
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - rotating-start one-hot arbiter; pointer 0 gives fixed priority
module rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     ptr_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0]     idx_o
);

  logic [NUM_PORTS-1:0] req_rot;
  logic [IDX_W:0]       pos;

  // Rotate so that the pointer position lands at bit 0 of req_rot
  assign req_rot = NUM_PORTS'({req_i, req_i} >> ptr_i);

  // Scan downwards so the closest requester after the pointer is the one left in pos
  always_comb begin
    pos   = '0;
    idx_o = '0;
    gnt_o = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        pos = {1'b0, ptr_i} + (IDX_W + 1)'(k);
        if (pos >= (IDX_W + 1)'(NUM_PORTS)) begin
          pos = pos - (IDX_W + 1)'(NUM_PORTS);
        end
      end
    end
    idx_o = pos[IDX_W-1:0];
    if (|req_i) begin
      gnt_o = NUM_PORTS'(1) << idx_o;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - N-port arbiter in front of a fixed-latency single-ported memory
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS    = 4,
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int ARB_MODE     = 0,
  parameter int SWAP_BYTES   = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_PORTS-1:0]        req_i,
  input  logic [NUM_PORTS-1:0]        we_i,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr_i,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata_i,
  output logic [NUM_PORTS-1:0]        gnt_o,
  output logic [NUM_PORTS-1:0]        rvalid_o,
  output logic [DATA_W-1:0]           rdata_o,
  output logic                        mem_req_o,
  output logic                        mem_we_o,
  output logic [ADDR_W-1:0]           mem_addr_o,
  output logic [DATA_W-1:0]           mem_wdata_o,
  input  logic [DATA_W-1:0]           mem_rdata_i
);

  localparam int IDX_W  = $clog2(NUM_PORTS);
  localparam int OFFS_W = $clog2(DATA_W / 8);

  logic [IDX_W-1:0]     ptr_q, ptr_d, arb_ptr, gnt_idx;
  logic [NUM_PORTS-1:0] gnt_raw;
  logic                 any_gnt;
  logic                 sel_we;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  resp_tag_t            tag_in;
  resp_tag_t            pipe_q [READ_LATENCY];

  // Fixed priority is the rotating arbiter with its start point pinned to port 0
  assign arb_ptr = (ARB_MODE == int'(ARB_RR)) ? ptr_q : '0;

  rr_arbiter #(
    .NUM_PORTS(NUM_PORTS)
  ) u_arb (
    .req_i(req_i),
    .ptr_i(arb_ptr),
    .gnt_o(gnt_raw),
    .idx_o(gnt_idx)
  );

  // Grants are suppressed while reset is held so the memory sees no access
  assign gnt_o   = rst_ni ? gnt_raw : '0;
  assign any_gnt = |gnt_o;

  // One-hot select of the granted port's command fields
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (gnt_raw[k]) begin
        sel_we    = we_i[k];
        sel_addr  = addr_i[k*ADDR_W +: ADDR_W];
        sel_wdata = wdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

  assign mem_req_o   = any_gnt;
  assign mem_we_o    = any_gnt & sel_we;
  assign mem_addr_o  = any_gnt ? (sel_addr >> OFFS_W) : '0;
  assign mem_wdata_o = mem_we_o ? sel_wdata : '0;

  // Next start point is the port just after the winner; idle cycles leave it alone
  always_comb begin
    ptr_d = ptr_q;
    if (any_gnt) begin
      ptr_d = (gnt_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Tag entering the response pipeline: only granted reads produce a response
  always_comb begin
    tag_in         = '0;
    tag_in.valid   = mem_req_o & ~mem_we_o;
    tag_in.port_id = PORT_ID_W'(gnt_idx);
  end

  // Response shift register tracking which port each in-flight read belongs to
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= tag_in;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign rvalid_o = pipe_q[READ_LATENCY-1].valid ?
                    (NUM_PORTS'(1) << pipe_q[READ_LATENCY-1].port_id) : '0;

  generate
    if (SWAP_BYTES != 0) begin : g_swap
      assign rdata_o = DATA_W'(byte_swap(MAX_DATA_W'(mem_rdata_i), DATA_W / 8));
    end else begin : g_noswap
      assign rdata_o = mem_rdata_i;
    end
  endgenerate

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter (fixed/lat1/swap and rr/lat3/noswap)
module tb_mem_port_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req, we;
  logic [127:0] addr;
  logic [63:0]  wdata;
  logic [15:0]  mem_rdata;

  logic [3:0]  fx_gnt, fx_rvalid, rr_gnt, rr_rvalid;
  logic [15:0] fx_rdata, fx_mem_wdata, rr_rdata, rr_mem_wdata;
  logic        fx_mem_req, fx_mem_we, rr_mem_req, rr_mem_we;
  logic [31:0] fx_mem_addr, rr_mem_addr;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rr_ptr = 0;
  int fix_due [0:2047];
  int rr_due  [0:2047];

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .NUM_PORTS(4), .DATA_W(16), .ADDR_W(32), .READ_LATENCY(1), .ARB_MODE(0), .SWAP_BYTES(1)
  ) u_fix (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(fx_gnt), .rvalid_o(fx_rvalid), .rdata_o(fx_rdata), .mem_req_o(fx_mem_req),
    .mem_we_o(fx_mem_we), .mem_addr_o(fx_mem_addr), .mem_wdata_o(fx_mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  mem_port_arbiter #(
    .NUM_PORTS(4), .DATA_W(16), .ADDR_W(32), .READ_LATENCY(3), .ARB_MODE(1), .SWAP_BYTES(0)
  ) u_rr (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(rr_gnt), .rvalid_o(rr_rvalid), .rdata_o(rr_rdata), .mem_req_o(rr_mem_req),
    .mem_we_o(rr_mem_we), .mem_addr_o(rr_mem_addr), .mem_wdata_o(rr_mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  function automatic int win_fixed(input logic [3:0] r);
    for (int k = 0; k < 4; k++) if (r[k]) return k;
    return -1;
  endfunction

  function automatic int win_rr(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      int q;
      q = (p + k) % 4;
      if (r[q]) return q;
    end
    return -1;
  endfunction

  function automatic logic [15:0] swap16(input logic [15:0] d);
    return {d[7:0], d[15:8]};
  endfunction

  function automatic logic [57:0] exp_bus(input int w, input int rvp);
    logic [3:0]  g;
    logic        mr, mw;
    logic [31:0] a;
    logic [15:0] wd;
    logic [3:0]  rv;
    g = '0; mr = 1'b0; mw = 1'b0; a = '0; wd = '0; rv = '0;
    if (w >= 0) begin
      g  = 4'(1) << w;
      mr = 1'b1;
      mw = we[w];
      a  = addr[w*32 +: 32] >> 1;
      if (mw) wd = wdata[w*16 +: 16];
    end
    if (rvp >= 0) rv = 4'(1) << rvp;
    return {g, mr, mw, a, wd, rv};
  endfunction

  task automatic advance();
    int wf, wr;
    if (!rst_n) begin
      rr_ptr = 0;
      for (int i = cyc; i < 2048; i++) begin
        fix_due[i] = -1;
        rr_due[i]  = -1;
      end
    end else begin
      wf = win_fixed(req);
      wr = win_rr(req, rr_ptr);
      if (wf >= 0 && !we[wf]) fix_due[cyc+1] = wf;
      if (wr >= 0 && !we[wr]) rr_due[cyc+3] = wr;
      if (wr >= 0) rr_ptr = (wr + 1) % 4;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [57:0] got;
    rst_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0; mem_rdata = '0;
    @(negedge clk); #1;
    got = {fx_gnt, fx_mem_req, fx_mem_we, fx_mem_addr, fx_mem_wdata, fx_rvalid};
    n_cmp++;
    if (got !== 58'd0) begin n_err++; $display("FAIL reset_init_fix got=%h exp=0", got); end
    got = {rr_gnt, rr_mem_req, rr_mem_we, rr_mem_addr, rr_mem_wdata, rr_rvalid};
    n_cmp++;
    if (got !== 58'd0) begin n_err++; $display("FAIL reset_init_rr got=%h exp=0", got); end
    advance();
    rst_n = 1'b1; req = 4'b1111; we = '0;
    addr = {$urandom, $urandom, $urandom, $urandom}; wdata = {$urandom, $urandom};
    advance();
    advance();
    rst_n = 1'b0;
    #1;
    got = {fx_gnt, fx_mem_req, fx_mem_we, fx_mem_addr, fx_mem_wdata, fx_rvalid};
    n_cmp++;
    if (got !== 58'd0) begin n_err++; $display("FAIL reset_mid_fix got=%h exp=0", got); end
    got = {rr_gnt, rr_mem_req, rr_mem_we, rr_mem_addr, rr_mem_wdata, rr_rvalid};
    n_cmp++;
    if (got !== 58'd0) begin n_err++; $display("FAIL reset_mid_rr got=%h exp=0", got); end
    advance();
    advance();
    rst_n = 1'b1; req = '0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if ({fx_rvalid, rr_rvalid} !== 8'd0) begin
        n_err++; $display("FAIL reset_no_stray cyc=%0d got=%b exp=0", i, {fx_rvalid, rr_rvalid});
      end
      advance();
    end
  endtask

  task automatic test_fixed_read();
    req = 4'b0110; we = '0;
    addr[32 +: 32] = 32'h10; addr[64 +: 32] = 32'h44;
    mem_rdata = 16'h1234;
    #1;
    n_cmp++;
    if ({fx_gnt, fx_mem_we, fx_mem_addr} !== {4'b0010, 1'b0, 32'h8}) begin
      n_err++; $display("FAIL fixed_read_cmd got=%b/%b/%h exp=0010/0/8", fx_gnt, fx_mem_we, fx_mem_addr);
    end
    n_cmp++;
    if (rr_gnt !== 4'b0010) begin n_err++; $display("FAIL rr_first_gnt got=%b exp=0010", rr_gnt); end
    advance();
    req = '0;
    #1;
    n_cmp++;
    if ({fx_rvalid, fx_rdata} !== {4'b0010, 16'h3412}) begin
      n_err++; $display("FAIL fixed_read_resp got=%b/%h exp=0010/3412", fx_rvalid, fx_rdata);
    end
    n_cmp++;
    if (rr_rvalid !== 4'b0000) begin n_err++; $display("FAIL rr_early_rvalid got=%b exp=0000", rr_rvalid); end
    advance();
    advance();
    #1;
    n_cmp++;
    if ({rr_rvalid, rr_rdata} !== {4'b0010, 16'h1234}) begin
      n_err++; $display("FAIL rr_read_noswap got=%b/%h exp=0010/1234", rr_rvalid, rr_rdata);
    end
    advance();
  endtask

  task automatic test_rr_rotation();
    logic [3:0] seq [6];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    rst_n = 1'b0; req = '0;
    advance();
    rst_n = 1'b1; req = 4'b1111; we = '0;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_cmp++;
      if (rr_gnt !== seq[i]) begin n_err++; $display("FAIL rr_rotate step=%0d got=%b exp=%b", i, rr_gnt, seq[i]); end
      n_cmp++;
      if (fx_gnt !== 4'b0001) begin n_err++; $display("FAIL fixed_starve step=%0d got=%b exp=0001", i, fx_gnt); end
      advance();
    end
    req = '0;
    for (int i = 0; i < 4; i++) advance();
  endtask

  task automatic test_write();
    req = 4'b0100; we = 4'b0100;
    addr[64 +: 32] = 32'h20; wdata[32 +: 16] = 16'hBEEF;
    #1;
    n_cmp++;
    if ({fx_gnt, fx_mem_we, fx_mem_addr, fx_mem_wdata} !== {4'b0100, 1'b1, 32'h10, 16'hBEEF}) begin
      n_err++; $display("FAIL write_fix got=%b/%b/%h/%h exp=0100/1/10/beef", fx_gnt, fx_mem_we, fx_mem_addr, fx_mem_wdata);
    end
    n_cmp++;
    if ({rr_gnt, rr_mem_we, rr_mem_addr, rr_mem_wdata} !== {4'b0100, 1'b1, 32'h10, 16'hBEEF}) begin
      n_err++; $display("FAIL write_rr got=%b/%b/%h/%h exp=0100/1/10/beef", rr_gnt, rr_mem_we, rr_mem_addr, rr_mem_wdata);
    end
    advance();
    req = '0; we = '0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if ({fx_rvalid, rr_rvalid} !== 8'd0) begin
        n_err++; $display("FAIL write_no_rvalid cyc=%0d got=%b exp=0", i, {fx_rvalid, rr_rvalid});
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    int         ports [3];
    logic [3:0] ef, er;
    ports = '{3, 0, 2};
    we = '0;
    for (int j = 0; j < 6; j++) begin
      req = (j < 3) ? (4'(1) << ports[j]) : 4'b0000;
      ef = '0; er = '0;
      if (j >= 1 && j <= 3) ef = 4'(1) << ports[j-1];
      if (j >= 3) er = 4'(1) << ports[j-3];
      #1;
      n_cmp++;
      if (fx_rvalid !== ef) begin n_err++; $display("FAIL b2b_fix cyc=%0d got=%b exp=%b", j, fx_rvalid, ef); end
      n_cmp++;
      if (rr_rvalid !== er) begin n_err++; $display("FAIL b2b_rr cyc=%0d got=%b exp=%b", j, rr_rvalid, er); end
      advance();
    end
  endtask

  task automatic test_random();
    logic [57:0] got, exp;
    int          wf, wr, rf, rr;
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 39) != 0);
      req       = 4'($urandom);
      we        = 4'($urandom);
      addr      = {$urandom, $urandom, $urandom, $urandom};
      wdata     = {$urandom, $urandom};
      mem_rdata = 16'($urandom);
      wf = rst_n ? win_fixed(req) : -1;
      wr = rst_n ? win_rr(req, rr_ptr) : -1;
      rf = rst_n ? fix_due[cyc] : -1;
      rr = rst_n ? rr_due[cyc] : -1;
      #1;
      got = {fx_gnt, fx_mem_req, fx_mem_we, fx_mem_addr, fx_mem_wdata, fx_rvalid};
      exp = exp_bus(wf, rf);
      n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL rand_fix cyc=%0d got=%h exp=%h", cyc, got, exp); end
      got = {rr_gnt, rr_mem_req, rr_mem_we, rr_mem_addr, rr_mem_wdata, rr_rvalid};
      exp = exp_bus(wr, rr);
      n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL rand_rr cyc=%0d got=%h exp=%h", cyc, got, exp); end
      if (rf >= 0) begin
        n_cmp++;
        if (fx_rdata !== swap16(mem_rdata)) begin
          n_err++; $display("FAIL rand_fix_rdata cyc=%0d got=%h exp=%h", cyc, fx_rdata, swap16(mem_rdata));
        end
      end
      if (rr >= 0) begin
        n_cmp++;
        if (rr_rdata !== mem_rdata) begin
          n_err++; $display("FAIL rand_rr_rdata cyc=%0d got=%h exp=%h", cyc, rr_rdata, mem_rdata);
        end
      end
      advance();
    end
    rst_n = 1'b1;
    req = '0;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      fix_due[i] = -1;
      rr_due[i]  = -1;
    end
    test_reset();
    test_fixed_read();
    test_rr_rotation();
    test_write();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
